gcn_coo_aggregator: RTL and testbench

//  Post-transform stage of the GCN: reads FM*WM product rows, aggregates each node's row with its
//  COO neighbours (undirected, self term included) and emits per-node argmax class index.

---
 rtl/gcn_coo_aggregator_if.sv | 39 +++
 rtl/gcn_coo_aggregator.sv | 205 ++++++++++++++++++++
 tb/tb_gcn_coo_aggregator.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/gcn_coo_aggregator_if.sv
// Bus between the aggregator and its product-row / COO memories.
// Latency: none (wires only).
// Backpressure: none; memories answer combinationally in the cycle an address is presented.
//
// Signals:
//   start            slave->master  level request to launch a run
//   coo_address      master->slave  COO edge index
//   coo_in           slave->master  {src,dst} of the addressed edge
//   row_address      master->slave  product row index
//   row_in           slave->master  product row, one element per class
//   done             master->slave  run complete, answers stable
//   max_addi_answer  master->slave  argmax class per node
interface gcn_coo_aggregator_if #(
  parameter int NUM_OF_NODES      = 6,
  parameter int WEIGHT_COLS       = 3,
  parameter int COO_NUM_OF_COLS   = 6,
  parameter int DOT_PROD_WIDTH    = 16,
  parameter int COO_BW            = $clog2(COO_NUM_OF_COLS),
  parameter int ROW_AW            = $clog2(NUM_OF_NODES),
  parameter int MAX_ADDRESS_WIDTH = $clog2(WEIGHT_COLS)
);
  logic                                                 start;
  logic [COO_BW-1:0]                                    coo_address;
  logic [0:1][COO_BW-1:0]                               coo_in;
  logic [ROW_AW-1:0]                                    row_address;
  logic [0:WEIGHT_COLS-1][DOT_PROD_WIDTH-1:0]           row_in;
  logic                                                 done;
  logic [0:NUM_OF_NODES-1][MAX_ADDRESS_WIDTH-1:0]       max_addi_answer;

  // master = aggregator, slave = memories / controller
  modport master (
    input  start, coo_in, row_in,
    output coo_address, row_address, done, max_addi_answer
  );
  modport slave (
    output start, coo_in, row_in,
    input  coo_address, row_address, done, max_addi_answer
  );
endinterface

// File: rtl/gcn_coo_aggregator.sv
// GCN aggregation: sums each node's product row with its COO neighbours, then emits per-node argmax.
// Latency: start sampled -> done after 2N+3E edges when all edges are valid and distinct.
// Backpressure: none; start is ignored while busy and must drop in DONE before a new run.
//
// Ports: clk, reset (sync, active-high), bus (gcn_coo_aggregator_if.master: start, coo_address,
//   coo_in, row_address, row_in, done, max_addi_answer).
// Build option: GCN_AGG_SATURATE_EN makes every accumulate clamp at 2^ACC_WIDTH-1 instead of wrapping.
module gcn_coo_aggregator #(
  parameter int NUM_OF_NODES      = 6,
  parameter int WEIGHT_COLS       = 3,
  parameter int COO_NUM_OF_COLS   = 6,
  parameter int DOT_PROD_WIDTH    = 16,
  parameter int ACC_WIDTH         = 20,
  parameter int COO_BW            = $clog2(COO_NUM_OF_COLS),
  parameter int ROW_AW            = $clog2(NUM_OF_NODES),
  parameter int MAX_ADDRESS_WIDTH = $clog2(WEIGHT_COLS)
) (
  input  logic                   clk,
  input  logic                   reset,
  gcn_coo_aggregator_if.master   bus
);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_E0, S_E1, S_E2, S_ARGMAX, S_DONE} state_t;
  typedef enum logic [1:0] {ACC_NONE, ACC_LOAD, ACC_ADD} acc_op_t;
  typedef logic [0:WEIGHT_COLS-1][ACC_WIDTH-1:0] acc_row_t;

  state_t                                          r_state, w_state_nxt;
  logic [ROW_AW-1:0]                               r_node, w_node_nxt;
  logic [COO_BW-1:0]                               r_edge, w_edge_nxt;
  logic [COO_BW-1:0]                               r_src, r_dst;
  logic [ROW_AW-1:0]                               r_row_address, w_row_addr_nxt;
  logic [COO_BW-1:0]                               r_coo_address, w_coo_addr_nxt;
  logic                                            r_done, w_done_nxt;
  logic [0:NUM_OF_NODES-1][MAX_ADDRESS_WIDTH-1:0]  r_ans;
  acc_row_t                                        r_acc [NUM_OF_NODES];

  acc_op_t                                         w_acc_op;
  logic [ROW_AW-1:0]                               w_acc_idx;
  logic                                            w_ans_we, w_ans_clr, w_adv;
  logic                                            w_last_node, w_last_edge, w_edge_ok;
  logic [MAX_ADDRESS_WIDTH-1:0]                    w_best;
  logic [ACC_WIDTH-1:0]                            w_best_val;

  assign w_last_node = (r_node == ROW_AW'(NUM_OF_NODES - 1));
  assign w_last_edge = (r_edge == COO_BW'(COO_NUM_OF_COLS - 1));
  // An edge touching a node outside the graph is dropped after its fetch cycle.
  assign w_edge_ok   = (32'(bus.coo_in[0]) < 32'(NUM_OF_NODES)) &&
                       (32'(bus.coo_in[1]) < 32'(NUM_OF_NODES));

  // One accumulate step; product element is zero-extended into the accumulator.
  function automatic logic [ACC_WIDTH-1:0] f_add(input logic [ACC_WIDTH-1:0]      a,
                                                 input logic [DOT_PROD_WIDTH-1:0] b);
`ifdef GCN_AGG_SATURATE_EN
    logic [ACC_WIDTH:0] s;
    s = {1'b0, a} + (ACC_WIDTH+1)'(b);
    f_add = s[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : s[ACC_WIDTH-1:0];
`else
    f_add = a + ACC_WIDTH'(b);
`endif
  endfunction

  // Argmax over the current node; strict '>' keeps the lowest class on ties.
  always_comb begin
    w_best     = '0;
    w_best_val = r_acc[r_node][0];
    for (int c = 1; c < WEIGHT_COLS; c++) begin
      if (r_acc[r_node][c] > w_best_val) begin
        w_best_val = r_acc[r_node][c];
        w_best     = MAX_ADDRESS_WIDTH'(c);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_node_nxt     = r_node;
    w_edge_nxt     = r_edge;
    w_row_addr_nxt = r_row_address;
    w_coo_addr_nxt = r_coo_address;
    w_done_nxt     = r_done;
    w_acc_op       = ACC_NONE;
    w_acc_idx      = r_node;
    w_ans_we       = 1'b0;
    w_ans_clr      = 1'b0;
    w_adv          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt    = S_INIT;
          w_node_nxt     = '0;
          w_row_addr_nxt = '0;
          w_ans_clr      = 1'b1;
        end
      end
      S_INIT: begin
        w_acc_op  = ACC_LOAD;
        w_acc_idx = r_node;
        if (w_last_node) begin
          w_state_nxt    = S_E0;
          w_edge_nxt     = '0;
          w_coo_addr_nxt = '0;
        end else begin
          w_node_nxt     = r_node + 1'b1;
          w_row_addr_nxt = r_node + 1'b1;
        end
      end
      S_E0: begin
        // Fetch src row next, straight from the COO word being latched this cycle.
        if (w_edge_ok) begin
          w_state_nxt    = S_E1;
          w_row_addr_nxt = ROW_AW'(bus.coo_in[0]);
        end else begin
          w_adv = 1'b1;
        end
      end
      S_E1: begin
        w_acc_op  = ACC_ADD;
        w_acc_idx = ROW_AW'(r_dst);
        // Self-loop: the row was already added once, skip the reverse direction.
        if (r_src == r_dst) begin
          w_adv = 1'b1;
        end else begin
          w_state_nxt    = S_E2;
          w_row_addr_nxt = ROW_AW'(r_dst);
        end
      end
      S_E2: begin
        w_acc_op  = ACC_ADD;
        w_acc_idx = ROW_AW'(r_src);
        w_adv     = 1'b1;
      end
      S_ARGMAX: begin
        w_ans_we = 1'b1;
        if (w_last_node) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_node_nxt = r_node + 1'b1;
        end
      end
      S_DONE: begin
        if (!bus.start) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_adv) begin
      if (w_last_edge) begin
        w_state_nxt = S_ARGMAX;
        w_node_nxt  = '0;
      end else begin
        w_state_nxt    = S_E0;
        w_edge_nxt     = r_edge + 1'b1;
        w_coo_addr_nxt = r_edge + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_node        <= '0;
      r_edge        <= '0;
      r_src         <= '0;
      r_dst         <= '0;
      r_row_address <= '0;
      r_coo_address <= '0;
      r_done        <= 1'b0;
      r_ans         <= '0;
      for (int i = 0; i < NUM_OF_NODES; i++) r_acc[i] <= '0;
    end else begin
      r_node        <= w_node_nxt;
      r_edge        <= w_edge_nxt;
      r_row_address <= w_row_addr_nxt;
      r_coo_address <= w_coo_addr_nxt;
      r_done        <= w_done_nxt;
      if (r_state == S_E0) begin
        r_src <= bus.coo_in[0];
        r_dst <= bus.coo_in[1];
      end
      case (w_acc_op)
        ACC_LOAD: for (int c = 0; c < WEIGHT_COLS; c++)
                    r_acc[w_acc_idx][c] <= ACC_WIDTH'(bus.row_in[c]);
        ACC_ADD:  for (int c = 0; c < WEIGHT_COLS; c++)
                    r_acc[w_acc_idx][c] <= f_add(r_acc[w_acc_idx][c], bus.row_in[c]);
        default: ;
      endcase
      if (w_ans_clr)     r_ans         <= '0;
      else if (w_ans_we) r_ans[r_node] <= w_best;
    end
  end

  assign bus.coo_address     = r_coo_address;
  assign bus.row_address     = r_row_address;
  assign bus.done            = r_done;
  assign bus.max_addi_answer = r_ans;

endmodule

// File: tb/tb_gcn_coo_aggregator.sv
// Bench for gcn_coo_aggregator: directed graphs on a 20-bit and a 16-bit accumulator instance.
// Latency: n/a.
// Backpressure: n/a.
module tb_gcn_coo_aggregator;
  localparam int N = 6, WC = 3, E = 6, DW = 16;
  typedef logic [0:WC-1][DW-1:0] row_t;
  typedef logic [0:1][2:0]       coo_t;
  typedef logic [0:N-1][1:0]     ans_t;
  typedef struct { ans_t ans; int lat; } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0, checks = 0, errors = 0, launch_a = 0, launch_b = 0;
  exp_t q_a[$], q_b[$];
  row_t a_rows[8], b_rows[8];
  coo_t a_coo[8],  b_coo[8];

  gcn_coo_aggregator_if #(.NUM_OF_NODES(N), .WEIGHT_COLS(WC), .COO_NUM_OF_COLS(E),
                          .DOT_PROD_WIDTH(DW)) ifa ();
  gcn_coo_aggregator_if #(.NUM_OF_NODES(N), .WEIGHT_COLS(WC), .COO_NUM_OF_COLS(E),
                          .DOT_PROD_WIDTH(DW)) ifb ();

  gcn_coo_aggregator #(.NUM_OF_NODES(N), .WEIGHT_COLS(WC), .COO_NUM_OF_COLS(E),
                       .DOT_PROD_WIDTH(DW), .ACC_WIDTH(20)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  gcn_coo_aggregator #(.NUM_OF_NODES(N), .WEIGHT_COLS(WC), .COO_NUM_OF_COLS(E),
                       .DOT_PROD_WIDTH(DW), .ACC_WIDTH(16)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  // Memories answer in the same cycle as the address.
  assign ifa.row_in = a_rows[ifa.row_address];
  assign ifa.coo_in = a_coo[ifa.coo_address];
  assign ifb.row_in = b_rows[ifb.row_address];
  assign ifb.coo_in = b_coo[ifb.coo_address];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic done_of(input bit sel);
    return sel ? ifb.done : ifa.done;
  endfunction

  function automatic ans_t ans_of(input bit sel);
    return sel ? ifb.max_addi_answer : ifa.max_addi_answer;
  endfunction

  // Scoreboard pop on each rising done.
  task automatic score(input bit sel, input ans_t act, input int lat);
    exp_t e;
    checks++;
    if ((sel ? q_b.size() : q_a.size()) == 0) begin
      errors++;
      $display("FAIL unexpected_done dut%0d got answers %h want no result", sel, act);
      return;
    end
    if (sel) e = q_b.pop_front();
    else     e = q_a.pop_front();
    if (act !== e.ans) begin
      errors++;
      $display("FAIL answers dut%0d got %h want %h", sel, act, e.ans);
    end
    checks++;
    if (lat != e.lat) begin
      errors++;
      $display("FAIL latency dut%0d got %0d want %0d", sel, lat, e.lat);
    end
  endtask

  initial begin
    bit pa, pb;
    pa = 1'b0;
    pb = 1'b0;
    forever begin
      @(negedge clk);
      if (ifa.done && !pa) score(1'b0, ifa.max_addi_answer, cyc - launch_a);
      if (ifb.done && !pb) score(1'b1, ifb.max_addi_answer, cyc - launch_b);
      pa = ifa.done;
      pb = ifb.done;
    end
  end

  task automatic run(input bit sel, input ans_t exp, input int lat);
    exp_t e;
    bit   seen;
    e.ans = exp;
    e.lat = lat;
    if (sel) begin q_b.push_back(e); launch_b = cyc; ifb.start = 1'b1; end
    else     begin q_a.push_back(e); launch_a = cyc; ifa.start = 1'b1; end
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      seen = done_of(sel);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout dut%0d got done=0 want done=1 within 200 cycles", sel);
    end
    // start still high: must not relaunch
    repeat (3) @(negedge clk);
    chk("done_held", 64'(done_of(sel)), 64'd1);
    if (sel) ifb.start = 1'b0;
    else     ifa.start = 1'b0;
    @(negedge clk);
    chk("done_clear", 64'(done_of(sel)), 64'd0);
    chk("answers_kept", 64'(ans_of(sel)), 64'(exp));
  endtask

  task automatic clear_a();
    for (int i = 0; i < 8; i++) begin
      a_rows[i] = '0;
      a_coo[i]  = {3'd7, 3'd7};
    end
  endtask

  task automatic load_edge01_a();
    clear_a();
    a_rows[0] = {16'd0, 16'd0, 16'd9};
    a_rows[1] = {16'd4, 16'd0, 16'd0};
    a_rows[2] = {16'd1, 16'd7, 16'd3};
    a_rows[3] = {16'd2, 16'd2, 16'd8};
    a_rows[4] = {16'd6, 16'd6, 16'd1};
    a_rows[5] = {16'd0, 16'd3, 16'd3};
    a_coo[0]  = {3'd0, 3'd1};
  endtask

  initial begin
    ans_t wrap_exp;
    reset     = 1'b1;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    clear_a();
    for (int i = 0; i < 8; i++) begin
      b_rows[i] = '0;
      b_coo[i]  = {3'd7, 3'd7};
    end
    repeat (3) @(negedge clk);
    chk("rst_done_a", 64'(ifa.done), 64'd0);
    chk("rst_coo_a",  64'(ifa.coo_address), 64'd0);
    chk("rst_row_a",  64'(ifa.row_address), 64'd0);
    chk("rst_ans_a",  64'(ifa.max_addi_answer), 64'd0);
    chk("rst_done_b", 64'(ifb.done), 64'd0);
    chk("rst_coo_b",  64'(ifb.coo_address), 64'd0);
    chk("rst_row_b",  64'(ifb.row_address), 64'd0);
    chk("rst_ans_b",  64'(ifb.max_addi_answer), 64'd0);
    reset = 1'b0;

    // All edges out of range, one-hot rows
    clear_a();
    for (int i = 0; i < N; i++) a_rows[i][i % 3] = 16'd10;
    run(1'b0, {2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2}, 19);

    // Uniform rows, ring of valid edges: every class ties
    clear_a();
    for (int i = 0; i < N; i++) begin
      a_rows[i] = {16'd5, 16'd5, 16'd5};
      a_coo[i]  = {3'(i), 3'((i + 1) % N)};
    end
    run(1'b0, {N{2'd0}}, 31);

    // Self-loop (2,2), edge (2,3), edges touching node 6/7 dropped
    clear_a();
    a_rows[0] = {16'd0, 16'd0, 16'd1};
    a_rows[2] = {16'd5, 16'd0, 16'd0};
    a_rows[3] = {16'd0, 16'd12, 16'd0};
    a_rows[4] = {16'd0, 16'd3, 16'd0};
    a_rows[5] = {16'd0, 16'd0, 16'd2};
    a_rows[6] = {16'd0, 16'd9, 16'd0};
    a_rows[7] = {16'd0, 16'd9, 16'd0};
    a_coo[0]  = {3'd2, 3'd2};
    a_coo[1]  = {3'd2, 3'd3};
    a_coo[2]  = {3'd6, 3'd0};
    a_coo[3]  = {3'd0, 3'd6};
    a_coo[4]  = {3'd7, 3'd7};
    a_coo[5]  = {3'd5, 3'd6};
    run(1'b0, {2'd2, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2}, 22);

    // Single edge (0,1)
    load_edge01_a();
    run(1'b0, {2'd2, 2'd2, 2'd1, 2'd2, 2'd0, 2'd1}, 21);

    // 16-bit accumulator overflow on edge (0,1)
    b_rows[0] = {16'hFFF0, 16'h0000, 16'h0000};
    b_rows[1] = {16'h0020, 16'h0100, 16'h0000};
    b_coo[0]  = {3'd0, 3'd1};
`ifdef GCN_AGG_SATURATE_EN
    wrap_exp = {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`else
    wrap_exp = {2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
    run(1'b1, wrap_exp, 21);

    // Reset in the middle of the edge phase, then a clean rerun
    load_edge01_a();
    ifa.start = 1'b1;
    repeat (15) @(negedge clk);
    ifa.start = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_done", 64'(ifa.done), 64'd0);
    chk("midrst_ans",  64'(ifa.max_addi_answer), 64'd0);
    chk("midrst_row",  64'(ifa.row_address), 64'd0);
    chk("midrst_coo",  64'(ifa.coo_address), 64'd0);
    run(1'b0, {2'd2, 2'd2, 2'd1, 2'd2, 2'd0, 2'd1}, 21);

    repeat (4) @(negedge clk);
    chk("pending_a", 64'(q_a.size()), 64'd0);
    chk("pending_b", 64'(q_b.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
